// File: rtl/alu_issue_stage.sv
// Issue/capture stage around a combinational ALU: in-order request FIFO feeding
// the ALU inputs, and a result holding register with its own valid/ready handshake.
module alu_issue_stage #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              in_opcode,
    input  logic [DATA_W-1:0]       in_a,
    input  logic [DATA_W-1:0]       in_b,
    output logic [DATA_W-1:0]       alu_a,
    output logic [DATA_W-1:0]       alu_b,
    output logic [2:0]              alu_opcode,
    input  logic [DATA_W-1:0]       alu_result,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_result,
    output logic [2:0]              out_opcode,
    output logic                    out_err,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [2:0] OP_ILLEGAL = 3'b111;
    localparam logic [2:0] OP_SAFE    = 3'b110;

    typedef struct packed {
        logic [2:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } entry_t;

    entry_t              mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_result_q, out_result_d;
    logic [2:0]          out_opcode_q, out_opcode_d;
    logic                out_err_q, out_err_d;

    entry_t              head;
    logic                head_legal;
    logic                push;
    logic                load;

    assign in_ready   = (count_q != CNT_W'(DEPTH));
    assign push       = in_valid && in_ready;
    assign load       = (count_q != '0) && (!out_valid_q || out_ready);
    assign head       = mem_q[rd_ptr_q];
    assign head_legal = (count_q != '0) && (head.op != OP_ILLEGAL);

    // Empty FIFO or illegal head: feed the ALU a harmless op on zero operands.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        alu_a      = '0;
        alu_b      = '0;
        alu_opcode = OP_SAFE;
        if (head_legal) begin
            alu_a      = head.a;
            alu_b      = head.b;
            alu_opcode = head.op;
        end
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_opcode_d = out_opcode_q;
        out_err_d    = out_err_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (load) rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push, load})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (load) begin
            out_valid_d  = 1'b1;
            out_opcode_d = head.op;
            out_err_d    = (head.op == OP_ILLEGAL);
            out_result_d = (head.op == OP_ILLEGAL) ? '0 : alu_result;
        end else if (out_valid_q && out_ready && count_q == '0) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_opcode_q <= '0;
            out_err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_opcode_q <= out_opcode_d;
            out_err_q    <= out_err_d;
        end
    end

    // NOTE: storage is not reset; count gates every read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{op: in_opcode, a: in_a, b: in_b};
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_opcode = out_opcode_q;
    assign out_err    = out_err_q;
    assign count      = count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: behavioural ALU, occupancy model and
// expected-result queue checked by a negedge monitor.
module tb_alu_issue_stage;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_opcode;
    logic [DATA_W-1:0] in_a, in_b;
    logic [DATA_W-1:0] alu_a, alu_b;
    logic [2:0]        alu_opcode;
    logic [DATA_W-1:0] alu_result;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [2:0]        out_opcode;
    logic              out_err;
    logic [2:0]        count;

    alu_issue_stage #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_a(in_a), .in_b(in_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_opcode(out_opcode), .out_err(out_err), .count(count)
    );

    always #5 clk = ~clk;

    // Behavioural ALU; an illegal opcode returns a poison value so a leak shows up.
    function automatic logic [DATA_W-1:0] alu_fn(input logic [2:0] op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~a;
            3'd6:    return a << 1;
            default: return 16'hDEAD;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_opcode, alu_a, alu_b);

    typedef struct {
        logic [DATA_W-1:0] res;
        logic [2:0]        op;
        logic              err;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   m_cnt = 0;
    bit   m_held = 1'b0;
    bit   rand_bp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor + reference model: evaluated at negedge, describing the coming posedge.
    always @(negedge clk) begin
        bit   m_load, m_drain, m_push;
        exp_t e;
        if (rst) begin
            sb.delete();
            m_cnt  = 0;
            m_held = 1'b0;
        end else begin
            check("count", 32'(count), 32'(m_cnt));
            check("in_ready", 32'(in_ready), 32'(m_cnt < DEPTH));
            check("out_valid", 32'(out_valid), 32'(m_held));
            check("alu_opcode_legal", 32'(alu_opcode == 3'b111), 32'd0);
            if (m_held) begin
                if (sb.size() == 0) begin
                    check("sb_nonempty", 32'd0, 32'd1);
                end else begin
                    check("out_result", 32'(out_result), 32'(sb[0].res));
                    check("out_opcode", 32'(out_opcode), 32'(sb[0].op));
                    check("out_err", 32'(out_err), 32'(sb[0].err));
                    if (out_ready) void'(sb.pop_front());
                end
            end
            m_load  = (m_cnt != 0) && (!m_held || out_ready);
            m_drain = m_held && out_ready && (m_cnt == 0);
            m_push  = in_valid && (m_cnt < DEPTH);
            if (m_push) begin
                e.op  = in_opcode;
                e.err = (in_opcode == 3'b111);
                e.res = e.err ? '0 : alu_fn(in_opcode, in_a, in_b);
                sb.push_back(e);
            end
            m_cnt  = m_cnt + int'(m_push) - int'(m_load);
            m_held = m_load ? 1'b1 : (m_drain ? 1'b0 : m_held);
        end
    end

    always @(posedge clk) begin
        if (rand_bp) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        bit acc = 1'b0;
        int guard = 0;
        in_valid  = 1'b1;
        in_opcode = op;
        in_a      = a;
        in_b      = b;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            guard++;
        end
        in_valid = 1'b0;
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_opcode = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_result", 32'(out_result), 32'd0);
        rst = 1'b0;

        // Single ADD: result visible one edge after acceptance
        out_ready = 1'b1;
        tick();
        send(3'd0, 16'h0003, 16'h0004);
        tick();
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_result", 32'(out_result), 32'h0007);
        check("add_opcode", 32'(out_opcode), 32'd0);
        check("add_count", 32'(count), 32'd0);
        repeat (2) tick();

        // Back-to-back ops with pointer wrap
        send(3'd1, 16'h0000, 16'h0001);
        send(3'd2, 16'hF0F0, 16'hFF00);
        send(3'd3, 16'hF0F0, 16'h0F0F);
        send(3'd4, 16'hAAAA, 16'hFFFF);
        send(3'd5, 16'h00FF, 16'h1234);
        repeat (3) tick();

        // Backpressure: fill register + FIFO, then drain
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send(3'd0, 16'(i), 16'h0100);
        in_valid = 1'b1; in_opcode = 3'd1; in_a = 16'h0050; in_b = 16'h0010;
        @(negedge clk);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_count", 32'(count), 32'd4);
        check("bp_hold_result", 32'(out_result), 32'h0101);
        repeat (3) tick();
        out_ready = 1'b1;
        @(negedge clk);
        check("fullpop_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("fullpop_count", 32'(count), 32'd3);
        send(3'd1, 16'h0050, 16'h0010);
        repeat (6) tick();

        // Illegal opcode never reaches the ALU
        send(3'd7, 16'h1234, 16'h5678);
        check("ill_alu_opcode", 32'(alu_opcode), 32'd6);
        check("ill_alu_a", 32'(alu_a), 32'd0);
        tick();
        check("ill_err", 32'(out_err), 32'd1);
        check("ill_result", 32'(out_result), 32'd0);
        send(3'd0, 16'h0001, 16'h0001);
        repeat (3) tick();

        // Randomized traffic with random backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
        end
        rand_bp = 1'b0;
        tick();
        out_ready = 1'b1;
        for (int g = 0; g < 50 && (sb.size() != 0 || out_valid); g++) tick();
        check("drained", 32'(sb.size()), 32'd0);

        // Reset mid-stream with a held result and three buffered entries
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(3'd3, 16'(i), 16'h8000);
        check("pre_rst_count", 32'(count), 32'd3);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_result", 32'(out_result), 32'd0);
        check("mid_rst_opcode", 32'(out_opcode), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (8) tick();
        send(3'd4, 16'h0F0F, 16'h00FF);
        repeat (4) tick();
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
